// File: rtl/round_pkg.sv
// round_pkg: shared state and winner encodings for the round sequencer.
// Also imported by vga_top for overlay decoding.
package round_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN  = 3'd1;
  localparam logic [2:0] ST_FIGHT      = 3'd2;
  localparam logic [2:0] ST_KO         = 3'd3;
  localparam logic [2:0] ST_MATCH_OVER = 3'd4;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Binary seconds (0..99) to two packed BCD digits.
  function automatic logic [7:0] to_bcd(
    input int unsigned v
  );
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Two-digit BCD decrement that sticks at 00.
  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v == 8'h00) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/round_tick_gen.sv
// round_tick_gen: game-second prescaler.
// clear restarts the count so a fresh second begins next cycle.
module round_tick_gen #(
  parameter int unsigned TICK_COUNT = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW =
    (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the last cycle, restart on clear.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/round_controller.sv
// round_controller: countdown, round timer, KO detection and
// best-of-N scoring around the game core.
module round_controller
  import round_pkg::*;
#(
  parameter int unsigned TICK_COUNT    = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter int unsigned ROUND_SEC     = 99,
  parameter int unsigned KO_HOLD_SEC   = 2,
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned MAX_ROUNDS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       game_rst_n,
  output logic       fight_active,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [7:0] timer_bcd,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  localparam logic [1:0] CD_INIT    = 2'(COUNTDOWN_SEC);
  localparam logic [7:0] TIMER_INIT = to_bcd(ROUND_SEC);
  localparam logic [7:0] HOLD_INIT  = 8'(KO_HOLD_SEC);
  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0] LAST_ROUND = 3'(MAX_ROUNDS);

  logic [2:0] state_q, state_d;
  logic       start_prev_q, start_prev_d;
  logic [1:0] countdown_q, countdown_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] round_q, round_d;
  logic [1:0] p1_wins_q, p1_wins_d;
  logic [1:0] p2_wins_q, p2_wins_d;
  logic [7:0] hold_q, hold_d;
  logic       game_rst_n_q, game_rst_n_d;
  logic       fight_active_q, fight_active_d;
  winner_e    round_winner_q, round_winner_d;
  winner_e    match_winner_q, match_winner_d;

  logic       start_edge;
  logic       tick;
  logic       state_change;
  winner_e    outcome;
  winner_e    score_cmp;

  assign start_edge   = start_btn & ~start_prev_q;
  assign start_prev_d = start_btn;
  assign state_change = (state_d != state_q);

  round_tick_gen #(
    .TICK_COUNT (TICK_COUNT)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_change),
    .tick  (tick)
  );

  // Round outcome this cycle; KOs outrank the timeout.
  always_comb begin
    outcome = WIN_NONE;
    if (p1_health == 4'd0 && p2_health == 4'd0) begin
      outcome = WIN_DRAW;
    end else if (p1_health == 4'd0) begin
      outcome = WIN_P2;
    end else if (p2_health == 4'd0) begin
      outcome = WIN_P1;
    end else if (timer_q == 8'h00) begin
      if (p1_health > p2_health) begin
        outcome = WIN_P1;
      end else if (p2_health > p1_health) begin
        outcome = WIN_P2;
      end else begin
        outcome = WIN_DRAW;
      end
    end
  end

  // Match verdict by round-win count when the round cap is hit.
  always_comb begin
    score_cmp = WIN_DRAW;
    if (p1_wins_q > p2_wins_q) begin
      score_cmp = WIN_P1;
    end else if (p2_wins_q > p1_wins_q) begin
      score_cmp = WIN_P2;
    end
  end

  // Sequencer next-state and score updates.
  always_comb begin
    state_d        = state_q;
    countdown_d    = countdown_q;
    timer_d        = timer_q;
    round_d        = round_q;
    p1_wins_d      = p1_wins_q;
    p2_wins_d      = p2_wins_q;
    hold_d         = hold_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d        = ST_COUNTDOWN;
          countdown_d    = CD_INIT;
          round_d        = 3'd1;
          p1_wins_d      = 2'd0;
          p2_wins_d      = 2'd0;
          round_winner_d = WIN_NONE;
          match_winner_d = WIN_NONE;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (countdown_q <= 2'd1) begin
            state_d     = ST_FIGHT;
            countdown_d = 2'd0;
            timer_d     = TIMER_INIT;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      ST_FIGHT: begin
        if (tick) begin
          timer_d = bcd_dec(timer_q);
        end
        if (outcome != WIN_NONE) begin
          state_d        = ST_KO;
          hold_d         = HOLD_INIT;
          round_winner_d = outcome;
          if (outcome == WIN_P1 && p1_wins_q != 2'd3) begin
            p1_wins_d = p1_wins_q + 2'd1;
          end
          if (outcome == WIN_P2 && p2_wins_q != 2'd3) begin
            p2_wins_d = p2_wins_q + 2'd1;
          end
        end
      end
      ST_KO: begin
        if (tick) begin
          if (hold_q <= 8'd1) begin
            if (p1_wins_q == WIN_TARGET) begin
              state_d        = ST_MATCH_OVER;
              match_winner_d = WIN_P1;
            end else if (p2_wins_q == WIN_TARGET) begin
              state_d        = ST_MATCH_OVER;
              match_winner_d = WIN_P2;
            end else if (round_q == LAST_ROUND) begin
              state_d        = ST_MATCH_OVER;
              match_winner_d = score_cmp;
            end else begin
              state_d        = ST_COUNTDOWN;
              countdown_d    = CD_INIT;
              round_d        = round_q + 3'd1;
              round_winner_d = WIN_NONE;
            end
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
      ST_MATCH_OVER: begin
        if (start_edge) begin
          state_d        = ST_IDLE;
          countdown_d    = 2'd0;
          timer_d        = TIMER_INIT;
          round_d        = 3'd0;
          p1_wins_d      = 2'd0;
          p2_wins_d      = 2'd0;
          round_winner_d = WIN_NONE;
          match_winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Core reset and input gating follow the state being entered.
  always_comb begin
    game_rst_n_d   = (state_d == ST_FIGHT) ||
                     (state_d == ST_KO) ||
                     (state_d == ST_MATCH_OVER);
    fight_active_d = (state_d == ST_FIGHT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      start_prev_q   <= 1'b1;
      countdown_q    <= 2'd0;
      timer_q        <= TIMER_INIT;
      round_q        <= 3'd0;
      p1_wins_q      <= 2'd0;
      p2_wins_q      <= 2'd0;
      hold_q         <= 8'd0;
      game_rst_n_q   <= 1'b0;
      fight_active_q <= 1'b0;
      round_winner_q <= WIN_NONE;
      match_winner_q <= WIN_NONE;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_prev_d;
      countdown_q    <= countdown_d;
      timer_q        <= timer_d;
      round_q        <= round_d;
      p1_wins_q      <= p1_wins_d;
      p2_wins_q      <= p2_wins_d;
      hold_q         <= hold_d;
      game_rst_n_q   <= game_rst_n_d;
      fight_active_q <= fight_active_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign state        = state_q;
  assign game_rst_n   = game_rst_n_q;
  assign fight_active = fight_active_q;
  assign countdown    = countdown_q;
  assign timer_bcd    = timer_q;
  assign round_num    = round_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed scenarios plus random play,
// checked every cycle against a seconds-level match model.
module tb_round_controller;

  localparam int T    = 10;
  localparam int CD   = 3;
  localparam int RS   = 5;
  localparam int KOH  = 1;
  localparam int RTW  = 2;
  localparam int MAXR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic       game_rst_n;
  logic       fight_active;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [7:0] timer_bcd;
  logic [2:0] round_num;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_controller #(
    .TICK_COUNT    (T),
    .COUNTDOWN_SEC (CD),
    .ROUND_SEC     (RS),
    .KO_HOLD_SEC   (KOH),
    .ROUNDS_TO_WIN (RTW),
    .MAX_ROUNDS    (MAXR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .game_rst_n   (game_rst_n),
    .fight_active (fight_active),
    .state        (state),
    .countdown    (countdown),
    .timer_bcd    (timer_bcd),
    .round_num    (round_num),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .round_winner (round_winner),
    .match_winner (match_winner)
  );

  // Model: state code, cycles spent in state, seconds left, scores.
  int m_st, m_age, m_timer, m_round;
  int m_w1, m_w2, m_rw, m_mw;
  bit m_prev;
  bit m_armed = 1'b0;

  always @(posedge clk) begin
    int nst;
    int w;
    bit tk;
    bit ed;
    if (reset) begin
      m_st = 0; m_age = 0; m_timer = RS; m_round = 0;
      m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0;
      m_prev = 1'b1; m_armed = 1'b1;
    end else if (m_armed) begin
      nst = m_st;
      w = 0;
      tk = (m_age % T) == T - 1;
      ed = start_btn && !m_prev;
      case (m_st)
        0: if (ed) begin
          nst = 1; m_round = 1;
          m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0;
        end
        1: if (m_age == CD * T - 1) begin
          nst = 2; m_timer = RS;
        end
        2: begin
          if (p1_health == 0 && p2_health == 0) w = 3;
          else if (p1_health == 0) w = 2;
          else if (p2_health == 0) w = 1;
          else if (m_timer == 0)
            w = (p1_health > p2_health) ? 1 :
                (p2_health > p1_health) ? 2 : 3;
          if (tk && m_timer > 0) m_timer = m_timer - 1;
          if (w != 0) begin
            nst = 3; m_rw = w;
            if (w == 1 && m_w1 < 3) m_w1 = m_w1 + 1;
            if (w == 2 && m_w2 < 3) m_w2 = m_w2 + 1;
          end
        end
        3: if (m_age == KOH * T - 1) begin
          if (m_w1 == RTW) begin
            nst = 4; m_mw = 1;
          end else if (m_w2 == RTW) begin
            nst = 4; m_mw = 2;
          end else if (m_round == MAXR) begin
            nst = 4;
            m_mw = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
          end else begin
            nst = 1; m_round = m_round + 1; m_rw = 0;
          end
        end
        default: if (ed) begin
          nst = 0; m_timer = RS; m_round = 0;
          m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0;
        end
      endcase
      m_prev = start_btn;
      m_age = (nst != m_st) ? 0 : m_age + 1;
      m_st = nst;
    end
  end

  function automatic logic [25:0] exp_vec();
    int cd;
    logic [7:0] tb;
    cd = (m_st == 1) ? CD - m_age / T : 0;
    tb = 8'(((m_timer / 10) << 4) | (m_timer % 10));
    return {3'(m_st), (m_st >= 2), (m_st == 2), 2'(cd), tb,
            3'(m_round), 2'(m_w1), 2'(m_w2), 2'(m_rw), 2'(m_mw)};
  endfunction

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic [25:0] act;
    logic [25:0] exp;
    if (m_armed) begin
      act = {state, game_rst_n, fight_active, countdown, timer_bcd,
             round_num, p1_wins, p2_wins, round_winner, match_winner};
      exp = exp_vec();
      checks = checks + 1;
      if (act !== exp) begin
        errors = errors + 1;
        $display("FAIL cycle_cmp t=%0t got %h required %h",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // One clock; the emulated core restores health while held in reset.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (game_rst_n === 1'b0) begin
      p1_health = 4'd15;
      p2_health = 4'd15;
    end
  endtask

  task automatic wait_st(input int s, input int lim, input string nm);
    int n = 0;
    while (int'(state) != s && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, int'(state), s);
  endtask

  task automatic press();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    start_btn = 1'b0;
    p1_health = 4'd15;
    p2_health = 4'd15;
    repeat (3) cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_game_rst_n", int'(game_rst_n), 0);
    chk("rst_timer", int'(timer_bcd), 8'h05);
    chk("rst_round", int'(round_num), 0);
    reset = 1'b0;
    cyc();

    // Countdown then first fight.
    press();
    chk("cd_entry", int'(state), 1);
    chk("cd_load", int'(countdown), 3);
    cnt = 0;
    while (state == 3'd1 && cnt < 100) begin
      cnt++;
      cyc();
    end
    chk("cd_len", cnt, 30);
    chk("fight_state", int'(state), 2);
    chk("fight_timer", int'(timer_bcd), 8'h05);
    chk("fight_round", int'(round_num), 1);
    chk("fight_active", int'(fight_active), 1);

    // P2 knocked out.
    p2_health = 4'd0;
    cyc();
    chk("ko_state", int'(state), 3);
    chk("ko_winner", int'(round_winner), 1);
    chk("ko_p1_wins", int'(p1_wins), 1);
    cnt = 0;
    while (state == 3'd3 && cnt < 50) begin
      cnt++;
      cyc();
    end
    chk("ko_len", cnt, 10);
    chk("r2_state", int'(state), 1);
    chk("r2_round", int'(round_num), 2);

    // Timeout with P2 ahead on health.
    wait_st(2, 40, "r2_fight");
    p1_health = 4'd7;
    p2_health = 4'd9;
    cnt = 0;
    while (state == 3'd2 && cnt < 100) begin
      if (cnt == 10) chk("timer_04", int'(timer_bcd), 8'h04);
      if (cnt == 49) chk("timer_01", int'(timer_bcd), 8'h01);
      if (cnt == 50) chk("timer_00", int'(timer_bcd), 8'h00);
      cnt++;
      cyc();
    end
    chk("fight_len", cnt, 51);
    chk("to_winner", int'(round_winner), 2);
    chk("to_p2_wins", int'(p2_wins), 1);

    // Round 3: P1 takes the match; start is ignored during KO.
    wait_st(1, 20, "r3_cd");
    wait_st(2, 40, "r3_fight");
    p2_health = 4'd0;
    cyc();
    chk("r3_p1_wins", int'(p1_wins), 2);
    press();
    chk("ko_ignores_start", int'(state), 3);
    wait_st(4, 20, "mo_p1");
    chk("mw_p1", int'(match_winner), 1);
    repeat (5) cyc();
    chk("mo_hold", int'(state), 4);
    press();
    chk("mo_to_idle", int'(state), 0);
    chk("idle_p1_wins", int'(p1_wins), 0);
    chk("idle_p2_wins", int'(p2_wins), 0);
    cyc();

    // Five draws reach the round cap.
    press();
    for (int r = 1; r <= 5; r++) begin
      wait_st(2, 40, "draw_fight");
      p1_health = 4'd0;
      p2_health = 4'd0;
      cyc();
      chk("draw_winner", int'(round_winner), 3);
      if (r < 5) wait_st(1, 20, "draw_next");
      else wait_st(4, 20, "draw_mo");
    end
    chk("draw_mw", int'(match_winner), 3);
    chk("draw_round", int'(round_num), 5);
    chk("draw_wins", int'({p1_wins, p2_wins}), 0);

    // Reset mid-fight with start held through it.
    press();
    cyc();
    press();
    wait_st(2, 40, "rst_fight");
    repeat (3) cyc();
    start_btn = 1'b1;
    reset = 1'b1;
    cyc();
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_game_rst_n", int'(game_rst_n), 0);
    chk("mid_rst_timer", int'(timer_bcd), 8'h05);
    reset = 1'b0;
    repeat (5) cyc();
    chk("held_start_idle", int'(state), 0);
    start_btn = 1'b0;
    cyc();
    press();
    chk("repress_cd", int'(state), 1);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      reset = ($urandom_range(0, 1499) == 0);
      start_btn = ($urandom_range(0, 19) == 0);
      if (state == 3'd2) begin
        if ($urandom_range(0, 7) == 0)
          p1_health = (p1_health > 4'($urandom_range(1, 8))) ?
                      p1_health - 4'($urandom_range(1, 8)) : 4'd0;
        if ($urandom_range(0, 7) == 0)
          p2_health = (p2_health > 4'd5) ? p2_health - 4'd5 : 4'd0;
        if ($urandom_range(0, 59) == 0) begin
          p1_health = 4'd0;
          p2_health = 4'd0;
        end
      end
    end
    reset = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
